fpadd_seq_ctrl: RTL and testbench

//  Parametrised sequencing FSM for the multi-cycle floating-point adder. Per accepted Go it drives

---
 rtl/fpadd_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_fpadd_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_seq_ctrl.sv
// fpadd_seq_ctrl
// Sequencing FSM for the multi-cycle floating-point adder. Each accepted Go
// walks through alignment, normalisation, rounding and at most one post-round
// renormalisation. The result exponent is tracked here, and overflow and
// underflow are flagged here as well.
//
// Optional feature macro: FPADD_ZERO_BYPASS_EN
//   defined   : a zero sum (no leading one found) goes straight from ALIGN to
//               DONE and sets Zero with ResExp cleared
//   undefined : Zero is tied low and a zero sum takes NOSHIFT -> ROUND -> DONE
//
// Ports
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   Go                           start request, accepted only when idle
//   ExpSet, ExpDiff, ExpMax      exponent comparison results for the operands
//   FFOValid, FFOIndex           leading-one detector on the aligned sum
//   RoundCarry                   carry out of the rounded mantissa
//   Busy, Done                   handshake (Done is a one-cycle pulse)
//   SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount
//                                alignment shifter/mux controls
//   SREn, SLEn, NoShift, IncrEn, DecrEn, ShiftAmount
//                                normaliser controls
//   SelExpMuxR, SelManMuxR       post-round renormalise selects
//   ResExp, Overflow, Underflow, Zero
//                                result exponent and flags, held until next Go

module fpadd_seq_ctrl #(
   parameter int EXPBITS      = 8,
   parameter int MANTISSABITS = 23,
   localparam int SW          = $clog2(MANTISSABITS + 2)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Go,
   input  logic               ExpSet,
   input  logic [EXPBITS-1:0] ExpDiff,
   input  logic [EXPBITS-1:0] ExpMax,
   input  logic               FFOValid,
   input  logic [SW-1:0]      FFOIndex,
   input  logic               RoundCarry,
   output logic               Busy,
   output logic               Done,
   output logic               SelExpMux,
   output logic               SelSRMuxL,
   output logic               SelSRMuxG,
   output logic               ShiftRightEnable,
   output logic [SW-1:0]      ShiftRightAmount,
   output logic               SREn,
   output logic               SLEn,
   output logic               NoShift,
   output logic               IncrEn,
   output logic               DecrEn,
   output logic [SW-1:0]      ShiftAmount,
   output logic               SelExpMuxR,
   output logic               SelManMuxR,
   output logic [EXPBITS-1:0] ResExp,
   output logic               Overflow,
   output logic               Underflow,
   output logic               Zero
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ALIGN   = 3'd1;
   localparam logic [2:0] NORM_R  = 3'd2;
   localparam logic [2:0] NORM_L  = 3'd3;
   localparam logic [2:0] NOSHIFT = 3'd4;
   localparam logic [2:0] ROUND   = 3'd5;
   localparam logic [2:0] RENORM  = 3'd6;
   localparam logic [2:0] DONE    = 3'd7;

`ifdef FPADD_ZERO_BYPASS_EN
   localparam logic [2:0] ZERO_NEXT = DONE;
`else
   localparam logic [2:0] ZERO_NEXT = NOSHIFT;
`endif

   localparam logic [SW-1:0]      IDX_HIDDEN = SW'(MANTISSABITS);
   localparam logic [SW-1:0]      IDX_CARRY  = SW'(MANTISSABITS + 1);
   localparam logic [EXPBITS-1:0] EXP_ONES   = '1;

   logic [2:0]         state_q, state_d;
   logic               expSet_q;
   logic [EXPBITS-1:0] expDiff_q;
   logic [SW-1:0]      ffoIdx_q;
   logic [EXPBITS-1:0] resExp_q;
   logic               overflow_q;
   logic               underflow_q;
`ifdef FPADD_ZERO_BYPASS_EN
   logic               zero_q;
`endif

   logic [SW-1:0]      alignAmt;
   logic [SW-1:0]      normShift;
   logic               incSat;
   logic [EXPBITS-1:0] incExp;
   logic               decUnder;
   logic [EXPBITS-1:0] decExp;

   // Alignment shift is clamped: shifting past the carry position already
   // pushes every mantissa bit out, so larger differences behave the same.
   always_comb begin
      alignAmt = SW'(expDiff_q);
      if (32'(expDiff_q) > 32'(MANTISSABITS + 1)) begin
         alignAmt = IDX_CARRY;
      end
   end

   // Exponent arithmetic for the increment (right-normalise/renormalise) and
   // decrement (left-normalise) paths. Increment saturates at all-ones, which
   // is the overflow condition. A left shift at least as large as the
   // exponent bottoms out at zero and flags underflow.
   always_comb begin
      normShift = IDX_HIDDEN - ffoIdx_q;
      incSat    = (resExp_q >= (EXP_ONES - EXPBITS'(1)));
      incExp    = incSat ? EXP_ONES : (resExp_q + EXPBITS'(1));
      decUnder  = (32'(normShift) >= 32'(resExp_q));
      decExp    = resExp_q - EXPBITS'(normShift);
   end

   // Next-state logic. The leading-one position seen at the end of ALIGN
   // picks the normalisation direction. An index beyond the carry bit is
   // treated like an already-normalised sum.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Go) state_d = ALIGN;
         ALIGN: begin
            if (!FFOValid)                    state_d = ZERO_NEXT;
            else if (FFOIndex == IDX_CARRY)   state_d = NORM_R;
            else if (FFOIndex == IDX_HIDDEN)  state_d = NOSHIFT;
            else if (FFOIndex < IDX_HIDDEN)   state_d = NORM_L;
            else                              state_d = NOSHIFT;
         end
         NORM_R, NORM_L, NOSHIFT: state_d = ROUND;
         ROUND:   state_d = RoundCarry ? RENORM : DONE;
         RENORM:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Operand information is captured on the
   // accepted Go. The exponent is then updated on leaving each state that
   // changes it, so it is stable from DONE until the next accepted Go.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         expSet_q    <= 1'b0;
         expDiff_q   <= '0;
         ffoIdx_q    <= '0;
         resExp_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifdef FPADD_ZERO_BYPASS_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (Go) begin
                  expSet_q    <= ExpSet;
                  expDiff_q   <= ExpDiff;
                  resExp_q    <= ExpMax;
                  overflow_q  <= 1'b0;
                  underflow_q <= 1'b0;
`ifdef FPADD_ZERO_BYPASS_EN
                  zero_q      <= 1'b0;
`endif
               end
            end
            ALIGN: begin
               ffoIdx_q <= FFOIndex;
`ifdef FPADD_ZERO_BYPASS_EN
               if (!FFOValid) begin
                  resExp_q <= '0;
                  zero_q   <= 1'b1;
               end
`endif
            end
            NORM_R, RENORM: begin
               resExp_q <= incExp;
               if (incSat) overflow_q <= 1'b1;
            end
            NORM_L: begin
               if (decUnder) begin
                  resExp_q    <= '0;
                  underflow_q <= 1'b1;
               end else begin
                  resExp_q <= decExp;
               end
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the registered state. In ALIGN, a zero
   // difference needs no shift. Otherwise the smaller operand (B when
   // ExpSet) is shifted right.
   always_comb begin
      Busy             = (state_q != IDLE);
      Done             = (state_q == DONE);
      SelExpMux        = 1'b0;
      SelSRMuxL        = 1'b0;
      SelSRMuxG        = 1'b0;
      ShiftRightEnable = 1'b0;
      ShiftRightAmount = '0;
      if (state_q == ALIGN) begin
         ShiftRightAmount = alignAmt;
         if (expDiff_q == '0) begin
            SelExpMux = 1'b1;
            SelSRMuxG = 1'b1;
         end else if (expSet_q) begin
            ShiftRightEnable = 1'b1;
            SelExpMux        = 1'b1;
            SelSRMuxG        = 1'b1;
         end else begin
            ShiftRightEnable = 1'b1;
            SelSRMuxL        = 1'b1;
         end
      end
      SREn        = (state_q == NORM_R) || (state_q == RENORM);
      IncrEn      = SREn;
      SLEn        = (state_q == NORM_L);
      DecrEn      = SLEn;
      NoShift     = (state_q == NOSHIFT);
      ShiftAmount = '0;
      if (state_q == NORM_R) ShiftAmount = SW'(1);
      if (state_q == NORM_L) ShiftAmount = normShift;
      SelExpMuxR  = (state_q == RENORM);
      SelManMuxR  = (state_q == RENORM);
   end

   assign ResExp    = resExp_q;
   assign Overflow  = overflow_q;
   assign Underflow = underflow_q;
`ifdef FPADD_ZERO_BYPASS_EN
   assign Zero      = zero_q;
`else
   assign Zero      = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// tb_fpadd_seq_ctrl
// Self-checking bench for fpadd_seq_ctrl (EXPBITS=8, MANTISSABITS=23).
// For each operation, a behavioural model works out the expected output
// vector for every cycle, from Go until the first idle cycle after Done,
// and queues it. A compare process pops one vector per cycle on the
// falling edge. A few literal checks pin the model's results.

module tb_fpadd_seq_ctrl;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       selExpMux;
      logic       selSRMuxL;
      logic       selSRMuxG;
      logic       sre;
      logic [4:0] sra;
      logic       srEn;
      logic       slEn;
      logic       noShift;
      logic       incr;
      logic       decr;
      logic [4:0] shAmt;
      logic       selExpMuxR;
      logic       selManMuxR;
      logic [7:0] resExp;
      logic       ovf;
      logic       unf;
      logic       zero;
   } obs_t;

   logic       clock;
   logic       reset;
   logic       go;
   logic       expSet;
   logic [7:0] expDiff;
   logic [7:0] expMax;
   logic       ffoValid;
   logic [4:0] ffoIndex;
   logic       roundCarry;
   logic       busy, done, selExpMux, selSRMuxL, selSRMuxG, shiftRightEnable;
   logic [4:0] shiftRightAmount;
   logic       srEn, slEn, noShift, incrEn, decrEn;
   logic [4:0] shiftAmount;
   logic       selExpMuxR, selManMuxR;
   logic [7:0] resExp;
   logic       overflow, underflow, zero;

   obs_t       act;
   obs_t       expQ[$];
   string      nameQ[$];
   int         assertCount = 0;
   int         failCount   = 0;
   int         cyc         = 0;
   int         goCyc       = 0;
   int         doneCyc     = -1;
   int         lastSra     = -1;
   int         lastShAmt   = -1;
   logic [7:0] heldRes     = '0;
   logic       heldOvf     = 1'b0;
   logic       heldUnf     = 1'b0;
   logic       heldZero    = 1'b0;

   fpadd_seq_ctrl #(.EXPBITS(8), .MANTISSABITS(23)) dut (
      .Clock(clock), .Reset(reset), .Go(go), .ExpSet(expSet), .ExpDiff(expDiff),
      .ExpMax(expMax), .FFOValid(ffoValid), .FFOIndex(ffoIndex), .RoundCarry(roundCarry),
      .Busy(busy), .Done(done), .SelExpMux(selExpMux), .SelSRMuxL(selSRMuxL),
      .SelSRMuxG(selSRMuxG), .ShiftRightEnable(shiftRightEnable),
      .ShiftRightAmount(shiftRightAmount), .SREn(srEn), .SLEn(slEn), .NoShift(noShift),
      .IncrEn(incrEn), .DecrEn(decrEn), .ShiftAmount(shiftAmount),
      .SelExpMuxR(selExpMuxR), .SelManMuxR(selManMuxR), .ResExp(resExp),
      .Overflow(overflow), .Underflow(underflow), .Zero(zero)
   );

   assign act = {busy, done, selExpMux, selSRMuxL, selSRMuxG, shiftRightEnable,
                 shiftRightAmount, srEn, slEn, noShift, incrEn, decrEn, shiftAmount,
                 selExpMuxR, selManMuxR, resExp, overflow, underflow, zero};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] timeout");
   end

   // Per-cycle comparison against the model's queued expectations.
   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (done) doneCyc = cyc;
         if (shiftRightEnable) lastSra = int'(shiftRightAmount);
         if (slEn) lastShAmt = int'(shiftAmount);
         if (expQ.size() > 0) begin
            obs_t  e;
            string n;
            e = expQ.pop_front();
            n = nameQ.pop_front();
            assertCount++;
            if (act !== e) begin
               failCount++;
               $display("[TB] FAIL %s: got %h expected %h", n, act, e);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      assertCount++;
      if (got !== want) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic obs_t heldObs();
      obs_t e;
      e        = '0;
      e.resExp = heldRes;
      e.ovf    = heldOvf;
      e.unf    = heldUnf;
      e.zero   = heldZero;
      return e;
   endfunction

   task automatic pushExp(input obs_t e, input string n);
      expQ.push_back(e);
      nameQ.push_back(n);
   endtask

   // Issues one Go and queues the whole expected trace. Exponent handling follows
   // plain integer arithmetic on the adder's rules.
   task automatic applyStimulus(input string name, input bit es, input logic [7:0] diff,
                                input logic [7:0] emax, input bit fv, input logic [4:0] idx,
                                input bit rc, input bit goWhileBusy);
      obs_t e;
      int   r;
      int   sa;
      bit   ovf, unf, zr, bypass;
      int   kind; // 0 no shift, 1 right, 2 left
      @(posedge clock);
      #2;
      expSet = es; expDiff = diff; expMax = emax; ffoValid = fv; ffoIndex = idx;
      roundCarry = rc; go = 1'b1;
      goCyc = cyc; doneCyc = -1; lastSra = -1; lastShAmt = -1;

      pushExp(heldObs(), {name, " go"});

      e = '0; e.busy = 1'b1; e.resExp = emax;
      if (diff == 0) begin
         e.selExpMux = 1'b1; e.selSRMuxG = 1'b1;
      end else if (es) begin
         e.sre = 1'b1; e.selExpMux = 1'b1; e.selSRMuxG = 1'b1;
      end else begin
         e.sre = 1'b1; e.selSRMuxL = 1'b1;
      end
      e.sra = (diff > 24) ? 5'd24 : diff[4:0];
      pushExp(e, {name, " align"});

      r = int'(emax); ovf = 1'b0; unf = 1'b0; zr = 1'b0; bypass = 1'b0;
`ifdef FPADD_ZERO_BYPASS_EN
      bypass = !fv;
`endif
      if (!fv || idx > 24 || idx == 23) kind = 0;
      else if (idx == 24)               kind = 1;
      else                              kind = 2;

      if (bypass) begin
         r = 0; zr = 1'b1;
      end else begin
         e = '0; e.busy = 1'b1; e.resExp = 8'(r);
         if (kind == 1) begin
            e.srEn = 1'b1; e.incr = 1'b1; e.shAmt = 5'd1;
            r = r + 1;
            if (r >= 255) begin r = 255; ovf = 1'b1; end
         end else if (kind == 2) begin
            sa = 23 - int'(idx);
            e.slEn = 1'b1; e.decr = 1'b1; e.shAmt = 5'(sa);
            if (sa >= r) begin r = 0; unf = 1'b1; end
            else r = r - sa;
         end else begin
            e.noShift = 1'b1;
         end
         pushExp(e, {name, " norm"});

         e = '0; e.busy = 1'b1; e.resExp = 8'(r); e.ovf = ovf; e.unf = unf;
         pushExp(e, {name, " round"});

         if (rc) begin
            e = '0; e.busy = 1'b1; e.resExp = 8'(r); e.ovf = ovf; e.unf = unf;
            e.selExpMuxR = 1'b1; e.selManMuxR = 1'b1; e.srEn = 1'b1; e.incr = 1'b1;
            pushExp(e, {name, " renorm"});
            r = r + 1;
            if (r >= 255) begin r = 255; ovf = 1'b1; end
         end
      end

      e = '0; e.busy = 1'b1; e.done = 1'b1; e.resExp = 8'(r);
      e.ovf = ovf; e.unf = unf; e.zero = zr;
      pushExp(e, {name, " done"});

      heldRes = 8'(r); heldOvf = ovf; heldUnf = unf; heldZero = zr;
      pushExp(heldObs(), {name, " idle"});

      @(posedge clock); #2; go = 1'b0;
      if (goWhileBusy) begin
         @(posedge clock); #2; go = 1'b1;
         @(posedge clock); #2; go = 1'b0;
      end
      for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clock);
      if (expQ.size() != 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL %s drain: %0d expectations left, required 0", name, expQ.size());
         expQ.delete();
         nameQ.delete();
      end
   endtask

   initial begin
      int doneSeen;
      reset = 1'b1; go = 1'b0; expSet = 1'b0; expDiff = '0; expMax = '0;
      ffoValid = 1'b1; ffoIndex = '0; roundCarry = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("reset outputs", 64'(act), 64'd0);
      @(posedge clock); #2; reset = 1'b0;

      // 1: equal exponents, carry out, right normalise
      applyStimulus("t1", 1'b1, 8'd0, 8'h80, 1'b1, 5'd24, 1'b0, 1'b0);
      checkOutput("t1 resExp", 64'(resExp), 64'h81);
      checkOutput("t1 latency", 64'(doneCyc - goCyc - 1), 64'd4);

      // 2: B larger, clamped alignment, left normalise by 3, Go pulsed while busy
      applyStimulus("t2", 1'b0, 8'd40, 8'h80, 1'b1, 5'd20, 1'b0, 1'b1);
      checkOutput("t2 resExp", 64'(resExp), 64'h7D);
      checkOutput("t2 sra", 64'(lastSra), 64'd24);
      checkOutput("t2 shamt", 64'(lastShAmt), 64'd3);
      checkOutput("t2 busy after", 64'(busy), 64'd0);

      // 3: no shift, round carry, renormalise into overflow
      applyStimulus("t3", 1'b1, 8'd3, 8'hFE, 1'b1, 5'd23, 1'b1, 1'b0);
      checkOutput("t3 resExp", 64'(resExp), 64'hFF);
      checkOutput("t3 overflow", 64'(overflow), 64'd1);
      checkOutput("t3 latency", 64'(doneCyc - goCyc - 1), 64'd5);

      // 4: maximal left shift underflows
      applyStimulus("t4", 1'b1, 8'd1, 8'h10, 1'b1, 5'd0, 1'b0, 1'b0);
      checkOutput("t4 shamt", 64'(lastShAmt), 64'd23);
      checkOutput("t4 underflow", 64'(underflow), 64'd1);
      checkOutput("t4 resExp", 64'(resExp), 64'h00);

      // Boundary patterns: alignment 24 vs 25, saturation through both increments,
      // out-of-range index, left shift exactly one below exponent
      applyStimulus("b1", 1'b1, 8'd24, 8'h40, 1'b1, 5'd22, 1'b0, 1'b0);
      applyStimulus("b2", 1'b0, 8'd25, 8'hFE, 1'b1, 5'd24, 1'b1, 1'b0);
      applyStimulus("b3", 1'b1, 8'd7, 8'h33, 1'b1, 5'd30, 1'b1, 1'b0);
      applyStimulus("b4", 1'b0, 8'd1, 8'd6, 1'b1, 5'd18, 1'b0, 1'b0);
      checkOutput("b4 resExp", 64'(resExp), 64'h01);

      // 6: zero sum
      applyStimulus("t6", 1'b1, 8'd2, 8'h55, 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef FPADD_ZERO_BYPASS_EN
      checkOutput("t6 latency", 64'(doneCyc - goCyc - 1), 64'd2);
      checkOutput("t6 zero", 64'(zero), 64'd1);
      checkOutput("t6 resExp", 64'(resExp), 64'h00);
`else
      checkOutput("t6 latency", 64'(doneCyc - goCyc - 1), 64'd4);
      checkOutput("t6 zero", 64'(zero), 64'd0);
      checkOutput("t6 resExp", 64'(resExp), 64'h55);
`endif

      // 5: reset while in ROUND
      @(posedge clock); #2;
      expSet = 1'b1; expDiff = 8'd0; expMax = 8'h70; ffoValid = 1'b1;
      ffoIndex = 5'd24; roundCarry = 1'b1; go = 1'b1; doneCyc = -1;
      @(posedge clock); #2; go = 1'b0;         // ALIGN
      @(posedge clock);                        // NORM_R
      @(posedge clock); #2; reset = 1'b1;      // ROUND
      @(negedge clock);
      checkOutput("t5 busy in round", 64'(busy), 64'd1);
      @(negedge clock);
      checkOutput("t5 after reset", 64'(act), 64'd0);
      @(posedge clock); #2; reset = 1'b0;
      doneSeen = 0;
      repeat (4) begin
         @(negedge clock);
         if (done) doneSeen++;
      end
      checkOutput("t5 no done", 64'(doneSeen), 64'd0);
      heldRes = '0; heldOvf = 1'b0; heldUnf = 1'b0; heldZero = 1'b0;

      // Normal operation resumes after the aborted one
      applyStimulus("t7", 1'b0, 8'd5, 8'h20, 1'b1, 5'd21, 1'b1, 1'b0);
      checkOutput("t7 resExp", 64'(resExp), 64'h1F);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
